// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
//   state_e    : controller state (boot, fetch, hold)
//   PC_INCR    : sequential fetch stride in bytes
//   ALIGN_MASK : low target bits that are forced to zero on a redirect
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned PC_INCR = 4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-stage bus between decode/hazard logic, instruction memory and the controller.
//   slave  : controller side (takes redirect/stall/ready, drives PCF and strobes)
//   master : environment side (drives redirect/stall/ready, observes controller outputs)
interface fetch_redirect_ctrl_if #(
  parameter int unsigned SIZE  = 31,
  parameter int unsigned CNT_W = 16
);

  logic             JumpD;
  logic             bequal;
  logic [SIZE:0]    jumpdest;
  logic [SIZE:0]    branchdest;
  logic             StallF;
  logic             imem_ready;
  logic [SIZE:0]    PCF;
  logic             imem_req;
  logic             fetch_valid;
  logic             FlushD;
  logic [CNT_W-1:0] redirect_cnt;

  modport slave (
    input  JumpD, bequal, jumpdest, branchdest, StallF, imem_ready,
    output PCF, imem_req, fetch_valid, FlushD, redirect_cnt
  );

  modport master (
    output JumpD, bequal, jumpdest, branchdest, StallF, imem_ready,
    input  PCF, imem_req, fetch_valid, FlushD, redirect_cnt
  );

endinterface

// File: rtl/fetch_redirect_ctrl_redirect_select.sv
// Priority mux for the decode-stage redirect target.
//   jump_i/branch_i         : resolved jump / taken branch
//   jumpdest_i/branchdest_i : candidate targets
//   redirect_o              : any redirect requested
//   target_o                : selected target, jump wins, word-aligned
module redirect_select
  import fetch_pkg::*;
#(
  parameter int unsigned SIZE = 31
) (
  input  logic          jump_i,
  input  logic          branch_i,
  input  logic [SIZE:0] jumpdest_i,
  input  logic [SIZE:0] branchdest_i,
  output logic          redirect_o,
  output logic [SIZE:0] target_o
);

  logic [SIZE:0] sel;

  always_comb begin
    sel        = jump_i ? jumpdest_i : branchdest_i;
    redirect_o = jump_i | branch_i;
    target_o   = {sel[SIZE:2], sel[1:0] & ~ALIGN_MASK};
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC owner: sequential advance, redirects, stalls and imem wait states.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of fetch_redirect_ctrl_if (redirect inputs, StallF,
//                imem_ready in; PCF, imem_req, fetch_valid, FlushD, redirect_cnt out)
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned    SIZE     = 31,
  parameter logic [SIZE:0]  RESET_PC = '0,
  parameter int unsigned    CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_redirect_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [SIZE:0]    pc_q, pc_d;
  logic [SIZE:0]    pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             redirect;
  logic [SIZE:0]    target;
  logic             advance;
  logic             cnt_inc;
  logic             req_raw, valid_raw, flush_raw;

  redirect_select #(
    .SIZE (SIZE)
  ) u_redirect_select (
    .jump_i       (bus.JumpD),
    .branch_i     (bus.bequal),
    .jumpdest_i   (bus.jumpdest),
    .branchdest_i (bus.branchdest),
    .redirect_o   (redirect),
    .target_o     (target)
  );

  assign advance = (state_q != StBoot) & ~bus.StallF & bus.imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    cnt_inc   = 1'b0;
    req_raw   = 1'b0;
    valid_raw = 1'b0;
    flush_raw = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        req_raw = ~bus.StallF;
        if (redirect) begin
          if (advance) begin
            pc_d      = target;
            flush_raw = 1'b1;
            cnt_inc   = 1'b1;
          end else begin
            // Blocked: park the target so it is applied exactly once later.
            pending_d = target;
            state_d   = StHold;
          end
        end else if (advance) begin
          valid_raw = 1'b1;
          pc_d      = pc_q + (SIZE+1)'(PC_INCR);
        end
      end
      StHold: begin
        // New redirects are ignored here; the parked target is from the older instruction.
        req_raw = ~bus.StallF;
        if (advance) begin
          pc_d      = pending_q;
          flush_raw = 1'b1;
          cnt_inc   = 1'b1;
          state_d   = StFetch;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
    cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PCF          = pc_q;
  assign bus.redirect_cnt = cnt_q;
  assign bus.imem_req     = rst_n & req_raw;
  assign bus.fetch_valid  = rst_n & valid_raw;
  assign bus.FlushD       = rst_n & flush_raw;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with hand-computed expectations.
module tb_fetch_redirect_ctrl;
  import fetch_pkg::*;

  localparam int unsigned   SIZE     = 31;
  localparam int unsigned   CNT_W    = 16;
  localparam logic [31:0]   RESET_PC = 32'h100;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fetch_redirect_ctrl_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

  fetch_redirect_ctrl #(
    .SIZE     (SIZE),
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2ns after a rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n          = 1'b0;
    bus.JumpD      = 1'b0;
    bus.bequal     = 1'b0;
    bus.jumpdest   = '0;
    bus.branchdest = '0;
    bus.StallF     = 1'b0;
    bus.imem_ready = 1'b1;

    // Reset state
    tick(); tick(); settle();
    chk("rst_pcf", 64'(bus.PCF), 64'h100);
    chk("rst_cnt", 64'(bus.redirect_cnt), 64'h0);
    chk("rst_req", 64'(bus.imem_req), 64'h0);
    chk("rst_valid", 64'(bus.fetch_valid), 64'h0);

    // Release: one boot cycle, then sequential fetch
    rst_n = 1'b1; settle();
    chk("boot_state", 64'(dut.state_q), 64'(StBoot));
    chk("boot_req", 64'(bus.imem_req), 64'h0);
    tick(); settle();
    chk("f0_state", 64'(dut.state_q), 64'(StFetch));
    chk("f0_req", 64'(bus.imem_req), 64'h1);
    chk("f0_pcf", 64'(bus.PCF), 64'h100);
    chk("f0_valid", 64'(bus.fetch_valid), 64'h1);
    tick(); settle();
    chk("f1_pcf", 64'(bus.PCF), 64'h104);
    chk("f1_valid", 64'(bus.fetch_valid), 64'h1);
    tick(); settle();
    chk("f2_pcf", 64'(bus.PCF), 64'h108);

    // Jump to 0x200
    bus.JumpD = 1'b1; bus.jumpdest = 32'h200; settle();
    chk("j1_flush", 64'(bus.FlushD), 64'h1);
    chk("j1_valid", 64'(bus.fetch_valid), 64'h0);
    tick(); bus.JumpD = 1'b0; settle();
    chk("j1_pcf", 64'(bus.PCF), 64'h200);
    chk("j1_cnt", 64'(bus.redirect_cnt), 64'h1);
    chk("j1_flush_off", 64'(bus.FlushD), 64'h0);

    // Jump and branch together: jump wins
    bus.JumpD = 1'b1; bus.bequal = 1'b1;
    bus.jumpdest = 32'h4000; bus.branchdest = 32'h3000; settle();
    chk("jb_flush", 64'(bus.FlushD), 64'h1);
    tick(); bus.JumpD = 1'b0; bus.bequal = 1'b0; settle();
    chk("jb_pcf", 64'(bus.PCF), 64'h4000);
    chk("jb_cnt", 64'(bus.redirect_cnt), 64'h2);

    // Branch blocked by StallF for 3 cycles; later redirects ignored in HOLD
    bus.bequal = 1'b1; bus.branchdest = 32'h3003; bus.StallF = 1'b1; settle();
    chk("st_req", 64'(bus.imem_req), 64'h0);
    chk("st_flush0", 64'(bus.FlushD), 64'h0);
    tick(); bus.JumpD = 1'b1; bus.jumpdest = 32'h7000; settle();
    for (int i = 0; i < 3; i++) begin
      chk("st_state", 64'(dut.state_q), 64'(StHold));
      chk("st_flush", 64'(bus.FlushD), 64'h0);
      chk("st_pcf", 64'(bus.PCF), 64'h4000);
      chk("st_cnt", 64'(bus.redirect_cnt), 64'h2);
      if (i < 2) begin
        tick(); settle();
      end
    end
    bus.StallF = 1'b0; settle();
    chk("hold_flush", 64'(bus.FlushD), 64'h1);
    chk("hold_valid", 64'(bus.fetch_valid), 64'h0);
    chk("hold_req", 64'(bus.imem_req), 64'h1);
    tick(); bus.JumpD = 1'b0; bus.bequal = 1'b0; settle();
    chk("hold_pcf", 64'(bus.PCF), 64'h3000);
    chk("hold_cnt", 64'(bus.redirect_cnt), 64'h3);
    chk("hold_state", 64'(dut.state_q), 64'(StFetch));
    chk("hold_flush_off", 64'(bus.FlushD), 64'h0);

    // Instruction memory wait states
    bus.imem_ready = 1'b0; settle();
    for (int i = 0; i < 2; i++) begin
      chk("ws_req", 64'(bus.imem_req), 64'h1);
      chk("ws_valid", 64'(bus.fetch_valid), 64'h0);
      chk("ws_pcf", 64'(bus.PCF), 64'h3000);
      tick(); settle();
    end
    bus.imem_ready = 1'b1; settle();
    chk("ws_valid_rdy", 64'(bus.fetch_valid), 64'h1);
    tick(); settle();
    chk("ws_pcf_next", 64'(bus.PCF), 64'h3004);

    // Reset during HOLD discards the pending target
    bus.JumpD = 1'b1; bus.jumpdest = 32'h500; bus.StallF = 1'b1; settle();
    tick(); settle();
    chk("rh_state", 64'(dut.state_q), 64'(StHold));
    bus.JumpD = 1'b0; bus.StallF = 1'b0; rst_n = 1'b0; settle();
    chk("rh_flush_gated", 64'(bus.FlushD), 64'h0);
    chk("rh_req_gated", 64'(bus.imem_req), 64'h0);
    tick(); settle();
    chk("rh_pcf", 64'(bus.PCF), 64'h100);
    chk("rh_cnt", 64'(bus.redirect_cnt), 64'h0);
    chk("rh_state_boot", 64'(dut.state_q), 64'(StBoot));
    rst_n = 1'b1; tick(); settle();
    chk("rh_pcf_after", 64'(bus.PCF), 64'h100);
    chk("rh_flush_after", 64'(bus.FlushD), 64'h0);
    chk("rh_valid_after", 64'(bus.fetch_valid), 64'h1);

    // PC wraps modulo 2^32
    bus.JumpD = 1'b1; bus.jumpdest = 32'hFFFF_FFFC; settle();
    tick(); bus.JumpD = 1'b0; settle();
    chk("wr_pcf", 64'(bus.PCF), 64'hFFFF_FFFC);
    chk("wr_cnt", 64'(bus.redirect_cnt), 64'h1);
    tick(); settle();
    chk("wr_pcf_wrap", 64'(bus.PCF), 64'h0);

    // Counter saturation: one redirect per cycle
    bus.JumpD = 1'b1; bus.jumpdest = 32'h100;
    repeat (65533) tick();
    settle();
    chk("sat_fffe", 64'(bus.redirect_cnt), 64'hFFFE);
    tick(); settle();
    chk("sat_ffff", 64'(bus.redirect_cnt), 64'hFFFF);
    repeat (5) tick();
    settle();
    chk("sat_hold", 64'(bus.redirect_cnt), 64'hFFFF);
    chk("sat_flush", 64'(bus.FlushD), 64'h1);
    bus.JumpD = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
